// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide engine: command opcodes,
// control states and the common reset/valid constants.
package hilo_muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    DIV_RUN = 2'b01,
    DONE    = 2'b10
  } state_e;

  localparam logic RST_ENABLE = 1'b1;
  localparam logic VALID      = 1'b1;
  localparam logic ZERO       = 1'b0;

endpackage

// File: rtl/hilo_muldiv_div_core.sv
// Unsigned restoring radix-2 divider datapath. One quotient bit per enabled
// step; the next-step remainder/quotient are exposed so the caller can capture the final step.
module div_core
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo_next,
  output logic [WIDTH-1:0] rem_next
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   diff;

  // Remainder stays below the divisor, so the shifted partial fits in WIDTH+1 bits
  // and the top bit of the difference is a clean borrow flag.
  always_comb begin
    partial = {rem_q, quo_q[WIDTH-1]};
    diff    = partial - {1'b0, dvs_q};
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = partial[WIDTH-1:0];
      quo_next = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
    end else if (step) begin
      rem_d = rem_next;
      quo_d = quo_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine for the EX stage; drives the HI/LO
// write bus with a one-cycle strobe and stalls the pipeline while dividing.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic [WIDTH-1:0] w_hi_data,
  output logic [WIDTH-1:0] w_lo_data,
  output logic             whi,
  output logic             wlo,
  output logic             busy,
  output logic             stall_req
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;

  op_e                op_cmd;
  logic               signed_op;
  logic               is_div;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_mag, prod;
  logic               div_load, div_step;
  logic [WIDTH-1:0]   quo_next, rem_next;

  assign op_cmd    = op_e'(op);
  assign signed_op = (op_cmd == OP_MULT) || (op_cmd == OP_DIV);
  assign is_div    = (op_cmd == OP_DIV) || (op_cmd == OP_DIVU);
  assign mag_a     = (signed_op && src_a[WIDTH-1]) ? -src_a : src_a;
  assign mag_b     = (signed_op && src_b[WIDTH-1]) ? -src_b : src_b;
  assign prod_mag  = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
  assign prod      = (signed_op && (src_a[WIDTH-1] ^ src_b[WIDTH-1])) ? -prod_mag : prod_mag;

  div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quo_next (quo_next),
    .rem_next (rem_next)
  );

  // Results are captured on the edge entering DONE, so the bus is valid for
  // the whole strobe cycle and holds afterwards.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    div_load = 1'b0;
    div_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start == VALID && !cancel) begin
          if (!is_div) begin
            hi_d    = prod[2*WIDTH-1:WIDTH];
            lo_d    = prod[WIDTH-1:0];
            state_d = DONE;
          end else if (src_b == '0) begin
            hi_d    = src_a;
            lo_d    = '1;
            state_d = DONE;
          end else begin
            div_load = 1'b1;
            cnt_d    = '0;
            negq_d   = signed_op && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            negr_d   = signed_op && src_a[WIDTH-1];
            state_d  = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        if (cancel) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          div_step = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            hi_d    = negr_q ? -rem_next : rem_next;
            lo_d    = negq_q ? -quo_next : quo_next;
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      negq_q  <= ZERO;
      negr_q  <= ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  // A flush arriving in the DONE cycle suppresses the write.
  assign whi       = (state_q == DONE) && !cancel;
  assign wlo       = whi;
  assign busy      = (state_q != IDLE);
  assign stall_req = (state_q == DIV_RUN);
  assign w_hi_data = hi_q;
  assign w_lo_data = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: a vector table of single operations plus
// hand-written sequences for cancel, reset mid-divide and ignored starts.
module tb_hilo_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, cancel;
  logic [1:0]   op;
  logic [W-1:0] src_a, src_b;
  logic [W-1:0] w_hi_data, w_lo_data;
  logic         whi, wlo, busy, stall_req;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [31:0] a, b, hi, lo;
    int         lat, stalls;
  } vec_t;

  vec_t vecs[11];

  hilo_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .cancel    (cancel),
    .w_hi_data (w_hi_data),
    .w_lo_data (w_lo_data),
    .whi       (whi),
    .wlo       (wlo),
    .busy      (busy),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one command and waits (bounded) for the strobe.
  task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output int lat, output int stalls,
                                output logic [31:0] hi, output logic [31:0] lo);
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; stalls = 0; hi = '0; lo = '0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (stall_req) stalls++;
      if (whi) begin
        lat = c;
        hi  = w_hi_data;
        lo  = w_lo_data;
        check_output("wlo_eq_whi", {63'd0, wlo}, 64'd1);
        break;
      end
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int lat, stalls, whi_cnt;
    logic [31:0] hi, lo;

    vecs[0]  = '{"mult_neg2x3",     2'b00, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 1,  0};
    vecs[1]  = '{"divu_100_7",      2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        33, 32};
    vecs[2]  = '{"div_m7_2",        2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 32};
    vecs[3]  = '{"div_min_m1",      2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 33, 32};
    vecs[4]  = '{"divu_5_0",        2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1,  0};
    vecs[5]  = '{"multu_max",       2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1,         1,  0};
    vecs[6]  = '{"mult_7_m3",       2'b00, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1,  0};
    vecs[7]  = '{"div_7_m2",        2'b10, 32'd7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, 33, 32};
    vecs[8]  = '{"divu_max_16",     2'b11, 32'hFFFF_FFFF, 32'd16,        32'hF,         32'h0FFF_FFFF, 33, 32};
    vecs[9]  = '{"multu_shift",     2'b01, 32'h1234_5678, 32'h10,        32'h1,         32'h2345_6780, 1,  0};
    vecs[10] = '{"div_min_by_zero", 2'b10, 32'h8000_0000, 32'h0,         32'h8000_0000, 32'hFFFF_FFFF, 1,  0};

    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_hi",   {32'd0, w_hi_data}, 64'd0);
    check_output("reset_lo",   {32'd0, w_lo_data}, 64'd0);
    check_output("reset_ctrl", {60'd0, whi, wlo, busy, stall_req}, 64'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat, stalls, hi, lo);
      check_output({vecs[i].name, "_lat"},    64'(lat),    64'(vecs[i].lat));
      check_output({vecs[i].name, "_stalls"}, 64'(stalls), 64'(vecs[i].stalls));
      check_output({vecs[i].name, "_hi"},     {32'd0, hi}, {32'd0, vecs[i].hi});
      check_output({vecs[i].name, "_lo"},     {32'd0, lo}, {32'd0, vecs[i].lo});
      @(negedge clk);
      check_output({vecs[i].name, "_after"}, {62'd0, whi, busy}, 64'd0);
    end

    // Cancel at iteration 10 of a divide: engine idles, no strobe follows.
    @(negedge clk);
    op = 2'b10; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    check_output("cancel_pre_stall", {63'd0, stall_req}, 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check_output("cancel_busy", {63'd0, busy}, 64'd0);
    whi_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (whi) whi_cnt++;
    end
    check_output("cancel_no_strobe", 64'(whi_cnt), 64'd0);
    apply_stimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, stalls, hi, lo);
    check_output("post_cancel_lat", 64'(lat), 64'd1);
    check_output("post_cancel_hi",  {32'd0, hi}, 64'hFFFF_FFFE);
    check_output("post_cancel_lo",  {32'd0, lo}, 64'h1);

    // A start pulsed while dividing must not disturb the running result.
    @(negedge clk);
    op = 2'b11; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; hi = '0; lo = '0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 5) begin
        op = 2'b00; src_a = 32'd3; src_b = 32'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (whi) begin
        lat = c; hi = w_hi_data; lo = w_lo_data;
        break;
      end
    end
    start = 1'b0;
    check_output("busy_start_lat", 64'(lat), 64'd33);
    check_output("busy_start_hi",  {32'd0, hi}, 64'd2);
    check_output("busy_start_lo",  {32'd0, lo}, 64'd14);
    @(negedge clk);
    check_output("busy_start_idle", {63'd0, busy}, 64'd0);

    // start together with cancel in IDLE is dropped.
    @(negedge clk);
    op = 2'b01; src_a = 32'd2; src_b = 32'd2; start = 1'b1; cancel = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    check_output("start_cancel_idle", {62'd0, busy, whi}, 64'd0);

    // Cancel raised during the DONE cycle suppresses the strobe.
    @(negedge clk);
    op = 2'b00; src_a = 32'd5; src_b = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; cancel = 1'b1;
    @(negedge clk);
    check_output("done_cancel_whi",  {62'd0, whi, wlo}, 64'd0);
    check_output("done_cancel_busy", {63'd0, busy}, 64'd1);
    @(posedge clk);
    #1 cancel = 1'b0;
    @(negedge clk);
    check_output("done_cancel_idle", {63'd0, busy}, 64'd0);

    // Reset at iteration 20 clears everything, data buses included.
    @(negedge clk);
    op = 2'b11; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("midrst_hi",   {32'd0, w_hi_data}, 64'd0);
    check_output("midrst_lo",   {32'd0, w_lo_data}, 64'd0);
    check_output("midrst_ctrl", {60'd0, whi, wlo, busy, stall_req}, 64'd0);
    rst = 1'b0;
    whi_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (whi || busy) whi_cnt++;
    end
    check_output("midrst_quiet", 64'(whi_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
